// File: rtl/seg_display_arbiter.sv
// Round-robin arbiter with minimum hold time sharing one 4-digit seven-segment scan driver.
// Optional feature macro: SEG_ARB_PREEMPT_EN (requester 0 preempts other owners on its rising request).
module seg_display_arbiter #(
  parameter int NREQ        = 3,
  parameter int HOLD_CYCLES = 1024,
  parameter int HOLD_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [16*NREQ-1:0]   data,
  output logic [NREQ-1:0]      gnt,
  output logic [3:0]           dig_one,
  output logic [3:0]           dig_two,
  output logic [3:0]           dig_three,
  output logic [3:0]           dig_four,
  output logic                 upd,
  output logic                 busy
);

  typedef enum logic {S_IDLE = 1'b0, S_HOLD = 1'b1} state_t;

  localparam logic [HOLD_W-1:0] RELOAD  = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0] T_ONE   = HOLD_W'(1);
  localparam logic [NREQ-1:0]   ONE_HOT = NREQ'(1);

  state_t            state, state_n;
  logic [NREQ-1:0]   gnt_n;
  logic [1:0]        last, last_n;
  logic [HOLD_W-1:0] timer, timer_n;
  logic [3:0]        req_ext;
  logic [63:0]       data_ext;
  logic              pick_valid;
  logic [1:0]        pick_idx;
  logic [2:0]        cand;
  logic              dig_load;
  logic [1:0]        dig_src;
  logic [15:0]       dig_val;
`ifdef SEG_ARB_PREEMPT_EN
  logic              req0_q;
`endif

  // Widen requests and data to four slots so indexing never depends on NREQ.
  always_comb begin
    req_ext                 = 4'b0000;
    req_ext[NREQ-1:0]       = req;
    data_ext                = 64'd0;
    data_ext[16*NREQ-1:0]   = data;
    dig_val                 = data_ext[{dig_src, 4'b0000} +: 16];
  end

  // Search order starts one past the most recent owner; the owner itself is checked last.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = 2'd0;
    cand       = 3'd0;
    for (int j = 0; j < NREQ; j++) begin
      cand = {1'b0, last} + 3'd1 + 3'(j);
      if (cand >= 3'(NREQ)) begin
        cand = cand - 3'(NREQ);
      end else begin
        cand = cand;
      end
      if (!pick_valid && req_ext[cand[1:0]]) begin
        pick_valid = 1'b1;
        pick_idx   = cand[1:0];
      end else begin
        pick_valid = pick_valid;
      end
    end
  end

  // Next-state logic; during HOLD `last` is always the current owner.
  always_comb begin
    state_n  = state;
    gnt_n    = gnt;
    last_n   = last;
    timer_n  = timer;
    dig_load = 1'b0;
    dig_src  = last;
    case (state)
      S_IDLE: begin
        if (pick_valid) begin
          state_n  = S_HOLD;
          gnt_n    = ONE_HOT << pick_idx;
          last_n   = pick_idx;
          timer_n  = RELOAD;
          dig_load = 1'b1;
          dig_src  = pick_idx;
        end else begin
          state_n  = S_IDLE;
        end
      end
      S_HOLD: begin
        dig_load = 1'b1;
`ifdef SEG_ARB_PREEMPT_EN
        if ((last != 2'd0) && req_ext[0] && !req0_q) begin
          gnt_n   = ONE_HOT;
          last_n  = 2'd0;
          timer_n = RELOAD;
          dig_src = 2'd0;
        end else
`endif
        if (!req_ext[last]) begin
          state_n  = S_IDLE;
          gnt_n    = {NREQ{1'b0}};
          dig_load = 1'b0;
        end else if (timer != {HOLD_W{1'b0}}) begin
          timer_n  = timer - T_ONE;
        end else begin
          // Owner is last in search order, so pick_idx is the owner only when nobody else waits.
          timer_n  = RELOAD;
          gnt_n    = ONE_HOT << pick_idx;
          last_n   = pick_idx;
          dig_src  = pick_idx;
        end
      end
      default: begin
        state_n = S_IDLE;
        gnt_n   = {NREQ{1'b0}};
      end
    endcase
  end

  // State, grant and display registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      gnt       <= {NREQ{1'b0}};
      last      <= 2'(NREQ - 1);
      timer     <= {HOLD_W{1'b0}};
      upd       <= 1'b0;
      busy      <= 1'b0;
      dig_one   <= 4'h0;
      dig_two   <= 4'h0;
      dig_three <= 4'h0;
      dig_four  <= 4'h0;
    end else begin
      state <= state_n;
      gnt   <= gnt_n;
      last  <= last_n;
      timer <= timer_n;
      upd   <= (gnt_n != gnt);
      busy  <= |gnt_n;
      if (dig_load) begin
        dig_one   <= dig_val[15:12];
        dig_two   <= dig_val[11:8];
        dig_three <= dig_val[7:4];
        dig_four  <= dig_val[3:0];
      end else begin
        dig_one   <= dig_one;
        dig_two   <= dig_two;
        dig_three <= dig_three;
        dig_four  <= dig_four;
      end
    end
  end

`ifdef SEG_ARB_PREEMPT_EN
  // Previous req[0] level for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req0_q <= 1'b0;
    end else begin
      req0_q <= req[0];
    end
  end
`endif

endmodule

// File: doc/seg_display_arbiter.md
# seg_display_arbiter

Shares the four-digit multiplexed seven-segment display driver between up to four requesters (e.g. counter, keypad echo, status code). Grants display ownership round-robin with a minimum hold time so the shown value cannot flicker between sources. Forwards the owner's four nibbles to the driver's digit inputs. Sits directly upstream of the BCD-to-seven-segment scan driver; one instance per display.

## Interface
- `NREQ`, 3 — number of requesters, legal range 2..4
- `HOLD_CYCLES`, 1024 — minimum ownership length in clk cycles, ≥2
- `HOLD_W`, 16 — hold-timer width; must satisfy HOLD_CYCLES-1 < 2^HOLD_W

Ports:
- `clk`  in  1  system clock, all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `req`  in  NREQ  level request per requester; held high while the requester wants the display
- `data`  in  16*NREQ  packed values; requester i occupies [16i+15:16i]; within a slice, [15:12]=leftmost digit … [3:0]=rightmost digit
- `gnt`  out  NREQ  one-hot owner, all-zero when idle
- `dig_one`, `dig_two`, `dig_three`, `dig_four`  out  4 each  nibbles to the scan driver, leftmost to rightmost
- `upd`  out  1  one-cycle pulse on any change of `gnt`
- `busy`  out  1  high while any owner holds the display

## Operation
- States: IDLE, HOLD.
- Round-robin pointer `last` holds the most recent owner. Search order starts at `last`+1 mod NREQ.
- IDLE:
  - If any `req` bit is high, grant the first requester in search order.
  - On grant: load timer = HOLD_CYCLES-1, set `last`, go to HOLD.
- HOLD, owner `o`:
  - Each cycle, `dig_*` register `data` slice `o`, so they track live updates.
  - If `req[o]` drops, release at the next edge regardless of the timer: `gnt`=0, go to IDLE. Arbitration resumes in IDLE on the following cycle, leaving a one-cycle gap.
  - Otherwise, while timer > 0, decrement the timer.
  - When timer = 0 and `req[o]` is high:
    - If another requester is high, hand over directly to the next one in search order. `gnt` changes in one edge with no gap; reload the timer.
    - Otherwise, keep `o` and reload the timer.
- IDLE: `dig_*` hold the last displayed value; `busy`=0.
- Simultaneous requests: resolved purely by search order from `last`+1. Requests that arrive mid-hold wait; they are not queued beyond their `req` level.
- Reset values: state IDLE, `gnt`=0, all `dig_*`=0, `upd`=0, `busy`=0, timer=0, `last`=NREQ-1 (requester 0 wins the first grant).
- Reset asserted mid-hold returns all outputs to their reset values immediately (asynchronous).

## Timing
- `req` sampled high at edge k in IDLE → `gnt`, `busy`, `dig_*` and `upd` valid after edge k+1.
- Ownership length with contention: exactly HOLD_CYCLES cycles of `gnt` per owner.
- Data latency: `data` change at edge k → `dig_*` updated after edge k+1.
- `upd`:
  - Asserted for exactly the cycle following any edge where `gnt` changed, including release to 0.
  - Never asserted for two consecutive cycles unless `gnt` changed on both edges.
- `busy` = OR of `gnt` bits, registered with `gnt`.

## Configuration
- `SEG_ARB_PREEMPT_EN` defined:
  - `req[0]` rising while another requester owns the display preempts at the next edge: `gnt` goes to bit 0, the timer reloads, `last`=0, `upd` pulses.
  - Requester 0 is never itself preempted.
- Not defined: requester 0 follows plain round-robin with no preemption.

## Test plan
Common settings: NREQ=3, HOLD_CYCLES=4.
- Reset then `req`=001, `data[15:0]`=16'h1234 → one cycle later `gnt`=001, `dig_*`=1,2,3,4, `upd` one-cycle pulse, `busy`=1.
- `req`=111 held constant from reset → `gnt` sequence 001,010,100,001, each held 4 cycles with no idle gap; `upd` pulses at each change.
- Owner 1 drops `req` after 2 cycles of hold → `gnt`=000 next cycle with an `upd` pulse. If `req[2]` is high, `gnt`=100 one cycle later.
- Owner changes `data` 16'h0009→16'h000A mid-hold → `dig_four` shows 9 then A one cycle later; `gnt` unchanged, no `upd`.
- `rst_n` pulled low mid-hold → `gnt`=0 and `dig_*`=0 without waiting for clk. After release, `req`=110 grants requester 1 first.
- With `SEG_ARB_PREEMPT_EN`: owner 2 in hold, `req[0]` rises → `gnt`=001 at the next edge, then held 4 cycles. Without the macro, requester 0 waits for requester 2's hold to expire.
